// File: rtl/digit_scan_seq.sv
// Digit scan sequencer for a 4-digit multiplexed display.
// Walks a 2-bit address through the digits. Each digit gets a BLANK phase
// (decoder disabled) followed by a SHOW phase (decoder enabled if the digit is
// unmasked). TICK pulses on the first BLANK cycle after each address advance.
// The debug state output exposes the FSM encoding for external checkers.
module digit_scan_seq #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        CLK,
  input  logic        RESET_L,
  input  logic        EN,
  input  logic [3:0]  DIG_EN,
  input  logic [15:0] D,
  output logic        B,
  output logic        A,
  output logic        G_L,
  output logic [3:0]  NIB,
  output logic        TICK,
  output logic [1:0]  DBG_STATE
);

  // One shared phase counter, wide enough for the longer of the two phases.
  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     addr, addr_n;
  logic           tick_q, tick_n;

  // State, counter, address and tick registers; reset acts immediately.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state  <= S_IDLE;
      cnt    <= '0;
      addr   <= 2'd0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      addr   <= addr_n;
      tick_q <= tick_n;
    end
  end

  // Next-state logic. EN low wins over everything and parks the FSM in IDLE
  // with the address held, so a re-enable resumes on the same digit.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    tick_n  = 1'b0;
    if (!EN) begin
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_BLANK;
          cnt_n   = '0;
        end
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n = S_SHOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt == DIV_LAST) begin
            // Address only moves here, so it is stable whenever G_L is low.
            state_n = S_BLANK;
            cnt_n   = '0;
            addr_n  = addr + 2'd1;
            tick_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs: decoder enable and nibble derive from registered state/address.
  always_comb begin
    G_L       = ~((state == S_SHOW) & DIG_EN[addr]);
    NIB       = D[addr*4 +: 4];
    B         = addr[1];
    A         = addr[0];
    TICK      = tick_q;
    DBG_STATE = state;
  end

endmodule

// File: tb/tb_digit_scan_seq.sv
// Bench for digit_scan_seq: directed scenarios followed by random stimulus.
// Expected outputs come from a timeline model: while enabled, cycle k of a run
// sits in digit slot k / (BLANK_CYC+DIV), offset k % (BLANK_CYC+DIV).
module tb_digit_scan_seq;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
  localparam int P         = DIV + BLANK_CYC;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        EN;
  logic [3:0]  DIG_EN;
  logic [15:0] D;
  logic        B, A, G_L, TICK;
  logic [3:0]  NIB;
  logic [1:0]  DBG_STATE;

  digit_scan_seq #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK(CLK), .RESET_L(RESET_L), .EN(EN), .DIG_EN(DIG_EN), .D(D),
    .B(B), .A(A), .G_L(G_L), .NIB(NIB), .TICK(TICK), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];   // {g_l, b, a, nib[3:0], tick}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit run;      // enabled and scanning
  int k;        // cycles since the run started (0 = first BLANK cycle)
  int a0;       // address the run started from
  int held;     // address held while idle

  function automatic int cur_addr();
    return run ? (a0 + k / P) % 4 : held;
  endfunction

  // Advance the model by one clock edge using the EN value sampled there.
  task automatic model_edge();
    if (!EN) begin
      if (run) held = cur_addr();
      run = 0;
    end else if (!run) begin
      run = 1;
      k   = 0;
      a0  = held;
    end else begin
      k++;
    end
  endtask

  function automatic logic [7:0] model_out();
    int ad, seg, off;
    logic g, t;
    ad = cur_addr();
    g  = 1'b1;
    t  = 1'b0;
    if (run) begin
      seg = k / P;
      off = k % P;
      if (off >= BLANK_CYC) g = ~DIG_EN[ad];
      t = (off == 0) && (seg > 0);
    end
    return {g, ad[1:0], D[ad*4 +: 4], t};
  endfunction

  // Replace this cycle's expectation after a mid-cycle input change.
  task automatic refresh_exp();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(model_out());
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse between clock edges, checked immediately.
  task automatic rst_pulse();
    RESET_L = 1'b0;
    #1;
    check("rst_g_l",  G_L, 1);
    check("rst_addr", {B, A}, 0);
    check("rst_tick", TICK, 0);
    #1;
    RESET_L = 1'b1;
    run  = 0;
    held = 0;
    refresh_exp();
  endtask

  // Step until the model reaches a SHOW offset of a given address.
  task automatic seek_show(input int ad, input int show_idx);
    int guard = 0;
    while (!(run && cur_addr() == ad && (k % P) == BLANK_CYC + show_idx)) begin
      step();
      guard++;
      if (guard > 100) begin
        check("seek_timeout", guard, 0);
        return;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("g_l",  G_L,    e[7]);
      check("addr", {B, A}, e[6:5]);
      check("nib",  NIB,    e[4:1]);
      check("tick", TICK,   e[0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    run = 0; k = 0; a0 = 0; held = 0;
    RESET_L = 1'b0;
    EN      = 1'b0;
    DIG_EN  = 4'b1111;
    D       = 16'h4321;
    #2;
    check("init_g_l",  G_L, 1);
    check("init_addr", {B, A}, 0);
    check("init_tick", TICK, 0);
    check("init_state", DBG_STATE, 0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET_L = 1'b1;
    steps(2);

    // Free run from reset: slot sequence, wrap after address 3, period 20.
    EN = 1'b1;
    steps(26);

    // Masked digit 2 keeps full timing with the decoder disabled.
    DIG_EN = 4'b1011;
    refresh_exp();
    steps(22);
    DIG_EN = 4'b1111;
    refresh_exp();

    // Drop EN on the second SHOW cycle of address 1, then resume.
    seek_show(1, 1);
    EN = 1'b0;
    steps(3);
    EN = 1'b1;
    steps(8);

    // Reset mid-SHOW of address 3, then restart from address 0.
    seek_show(3, 1);
    rst_pulse();
    steps(3);   // BLANK, SHOW0, SHOW1 at address 0

    // Data change mid-SHOW of address 0: NIB follows within the cycle.
    D = 16'h8765;
    refresh_exp();
    steps(10);

    // Random stimulus against the timeline model.
    for (int i = 0; i < 400; i++) begin
      step();
      EN = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) DIG_EN = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) D = 16'($urandom_range(0, 65535));
      refresh_exp();
      if ($urandom_range(0, 99) == 0) rst_pulse();
    end
    EN = 1'b1;
    steps(5);

    @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
